// File: rtl/algo_1r1rw_b35_scrub_ctrl.sv
// Background ECC scrubber and port sharer for the 1R1RW b35 memory top; host traffic always wins.
// Optional: ALGO_1R1RW_SCRUB_DERR_HALT_EN parks the scrubber in HALT after a double-bit error.
module algo_1r1rw_b35_scrub_ctrl #(
   parameter int WIDTH    = 32,
   parameter int BITADDR  = 13,
   parameter int NUMADDR  = 8192,
   parameter int DELAY    = 4,
   parameter int SCRBINTV = 16,
   parameter int BITINTV  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ready,
   input  logic               scrub_en,
   input  logic               h_read,
   input  logic [BITADDR-1:0] h_rd_adr,
   output logic               h_rd_vld,
   output logic [WIDTH-1:0]   h_rd_dout,
   output logic               h_rd_serr,
   output logic               h_rd_derr,
   input  logic               h_rw_write,
   input  logic               h_rw_read,
   input  logic [BITADDR-1:0] h_rw_addr,
   input  logic [WIDTH-1:0]   h_rw_din,
   output logic               read,
   output logic [BITADDR-1:0] rd_adr,
   input  logic               rd_vld,
   input  logic [WIDTH-1:0]   rd_dout,
   input  logic               rd_serr,
   input  logic               rd_derr,
   output logic               rw_read,
   output logic               rw_write,
   output logic [BITADDR-1:0] rw_addr,
   output logic [WIDTH-1:0]   rw_din,
   output logic [15:0]        serr_cnt,
   output logic [15:0]        derr_cnt,
   output logic [BITADDR-1:0] derr_adr,
   output logic               pass_done,
   output logic               scrub_busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] ISSUE = 3'd2;
   localparam logic [2:0] PEND  = 3'd3;
   localparam logic [2:0] WBACK = 3'd4;
   localparam logic [2:0] NEXT  = 3'd5;
`ifdef ALGO_1R1RW_SCRUB_DERR_HALT_EN
   localparam logic [2:0] HALT  = 3'd6;
   localparam logic [2:0] DERR_NEXT = HALT;
`else
   localparam logic [2:0] DERR_NEXT = NEXT;
`endif

   logic [2:0]         state;
   logic [BITADDR-1:0] ptr;
   logic [BITINTV-1:0] icnt;
   logic [WIDTH-1:0]   wb_data;
   logic               cancel;
   logic [DELAY-1:0]   tag_v, tag_h, tag_v_nxt, tag_h_nxt;
   logic               run, scrub_rd, scrub_ret, host_rw, hazard, wb_fire;
   logic               last_adr, intv_done, halted;

   assign run       = scrub_en & ready;
   assign scrub_rd  = run & (state == ISSUE) & ~h_read;
   assign read      = h_read | scrub_rd;
   assign rd_adr    = h_read ? h_rd_adr : (scrub_rd ? ptr : '0);

   assign h_rd_vld  = rd_vld & tag_v[DELAY-1] & tag_h[DELAY-1];
   assign h_rd_dout = h_rd_vld ? rd_dout : '0;
   assign h_rd_serr = h_rd_vld & rd_serr;
   assign h_rd_derr = h_rd_vld & rd_derr;
   assign scrub_ret = rd_vld & tag_v[DELAY-1] & ~tag_h[DELAY-1];

   assign host_rw   = h_rw_read | h_rw_write;
   assign hazard    = h_rw_write & (h_rw_addr == ptr);
   assign wb_fire   = run & (state == WBACK) & ~host_rw;
   assign rw_read   = h_rw_read;
   assign rw_write  = h_rw_write | wb_fire;
   assign rw_addr   = host_rw ? h_rw_addr : (wb_fire ? ptr : '0);
   assign rw_din    = host_rw ? h_rw_din : (wb_fire ? wb_data : '0);

   assign last_adr   = (ptr == BITADDR'(NUMADDR - 1));
   // Leave WAIT on the cycle the counter becomes SCRBINTV-1 so the issue lands SCRBINTV cycles after enable.
   assign intv_done  = (32'(icnt) + 32'd1) >= 32'(SCRBINTV - 1);
   assign scrub_busy = (state != IDLE);
`ifdef ALGO_1R1RW_SCRUB_DERR_HALT_EN
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif

   // Scrub-owned tags are dropped while disabled so a stale return can never reach a later PEND.
   always_comb begin
      tag_v_nxt    = '0;
      tag_h_nxt    = '0;
      tag_v_nxt[0] = read;
      tag_h_nxt[0] = h_read;
      for (int unsigned i = 1; i < DELAY; i++) begin
         tag_v_nxt[i] = tag_v[i-1];
         tag_h_nxt[i] = tag_h[i-1];
      end
      if (!run) tag_v_nxt = tag_v_nxt & tag_h_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
         tag_h <= '0;
      end else begin
         tag_v <= tag_v_nxt;
         tag_h <= tag_h_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         icnt      <= '0;
         wb_data   <= '0;
         cancel    <= 1'b0;
         serr_cnt  <= '0;
         derr_cnt  <= '0;
         derr_adr  <= '0;
         pass_done <= 1'b0;
      end else begin
         pass_done <= 1'b0;
         if (halted) begin
            if (!scrub_en) state <= IDLE;
         end else if (!run) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  icnt  <= '0;
                  state <= WAIT;
               end
               WAIT: begin
                  icnt <= icnt + 1'b1;
                  if (intv_done) state <= ISSUE;
               end
               ISSUE: if (!h_read) begin
                  cancel <= 1'b0;
                  state  <= PEND;
               end
               PEND: begin
                  if (hazard) cancel <= 1'b1;
                  if (scrub_ret) begin
                     if (rd_derr) begin
                        if (derr_cnt != '1) derr_cnt <= derr_cnt + 1'b1;
                        derr_adr <= ptr;
                        state    <= DERR_NEXT;
                     end else if (rd_serr) begin
                        if (serr_cnt != '1) serr_cnt <= serr_cnt + 1'b1;
                        wb_data <= rd_dout;
                        state   <= (cancel | hazard) ? NEXT : WBACK;
                     end else begin
                        state <= NEXT;
                     end
                  end
               end
               WBACK: if (hazard || !host_rw) state <= NEXT;
               NEXT: begin
                  ptr       <= last_adr ? '0 : ptr + 1'b1;
                  pass_done <= last_adr;
                  icnt      <= '0;
                  state     <= WAIT;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
